// File: rtl/shift_arbiter.sv
// shift_arbiter
//
// Shares a single barrel shifter between two requesters. A round-robin
// arbiter picks one request per cycle, the shared shifter computes the
// result from the granted requester's operands, and the result is captured
// in a one-entry output register that drains under its own valid/ready
// handshake. A drain and a new accept may happen on the same edge, so the
// block sustains one shift per cycle.
//
// Ports:
//   clk                 system clock, rising edge
//   rst                 asynchronous active-high reset
//   req0_valid/ready    requester 0 handshake
//   req0_in/cnt/op      requester 0 operand, shift count, op code
//   req1_*              same as requester 0, for requester 1
//   res_valid/ready     result handshake toward the consumer
//   res_out             shift result
//   res_id              requester that produced res_out
//
// Op codes: 0 rotate left, 1 shift left logical, 2 shift right arithmetic,
//           3 shift right logical. A count of 0 passes the operand through.

module shift_arbiter #(
  parameter int N = 16,
  parameter int C = 4,
  parameter int O = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_in,
  input  logic [C-1:0] req0_cnt,
  input  logic [O-1:0] req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_in,
  input  logic [C-1:0] req1_cnt,
  input  logic [O-1:0] req1_op,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_out,
  output logic         res_id
);

  localparam logic [O-1:0] opRol = O'(0);
  localparam logic [O-1:0] opSll = O'(1);
  localparam logic [O-1:0] opSra = O'(2);
  localparam logic [O-1:0] opSrl = O'(3);

  logic         prio;
  logic         anyValid;
  logic         grantId;
  logic         canAccept;
  logic         accept;
  logic [N-1:0] selIn;
  logic [C-1:0] selCnt;
  logic [O-1:0] selOp;
  logic [N-1:0] shifted;

  // Grant: a lone requester wins outright; on a tie the priority pointer
  // decides. The output slot can take a new result when it is empty or is
  // being drained this same cycle. Readys are forced low during reset.
  always_comb begin
    anyValid   = req0_valid | req1_valid;
    grantId    = (req0_valid && req1_valid) ? prio : req1_valid;
    canAccept  = !res_valid || res_ready;
    accept     = anyValid && canAccept && !rst;
    req0_ready = accept && !grantId;
    req1_ready = accept && grantId;
  end

  // Shared shifter, fed from whichever requester holds the grant.
  // For rotate, a zero count makes the right-shift term shift by N,
  // which yields zero and leaves the operand unchanged.
  always_comb begin
    selIn   = grantId ? req1_in  : req0_in;
    selCnt  = grantId ? req1_cnt : req0_cnt;
    selOp   = grantId ? req1_op  : req0_op;
    shifted = selIn;
    case (selOp)
      opRol:   shifted = (selIn << selCnt) | (selIn >> (N - int'(selCnt)));
      opSll:   shifted = selIn << selCnt;
      opSra:   shifted = N'($signed(selIn) >>> selCnt);
      opSrl:   shifted = selIn >> selCnt;
      default: shifted = selIn;
    endcase
  end

  // Output register and priority pointer. An accept always loads the slot
  // (replacing a result drained on the same edge) and hands the next tie
  // to the other requester. Without an accept, a completed drain just
  // clears valid; data and id keep their last values. Under backpressure
  // nothing here changes because accept is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_out   <= '0;
      res_id    <= 1'b0;
      prio      <= 1'b0;
    end else if (accept) begin
      res_valid <= 1'b1;
      res_out   <= shifted;
      res_id    <= grantId;
      prio      <= ~grantId;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares one barrel shifter between two requesters, for example the execute-stage ALU path and a secondary shift user such as an address/immediate formatter. Each requester presents operands under a valid/ready handshake. A round-robin arbiter grants one request per cycle and captures the shift result in a single-entry output register. The result is then delivered downstream with its requester ID under its own valid/ready handshake.

## Interface
Parameters:
- N, 16, data width.
- C, 4, shift-count width; legal counts are 0..2^C-1.
- O, 2, op-code width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a shift pending.
- req0_ready  out  1  requester 0's request is accepted this cycle.
- req0_in  in  N  requester 0 operand.
- req0_cnt  in  C  requester 0 shift count.
- req0_op  in  O  requester 0 op code.
- req1_valid, req1_ready, req1_in, req1_cnt, req1_op: same as requester 0, for requester 1.
- res_valid  out  1  output register holds a result.
- res_ready  in  1  consumer accepts the result this cycle.
- res_out  out  N  shift result.
- res_id  out  1  ID of the requester that produced res_out.

## Operation
- Op encoding:
  - 00 rotate left.
  - 01 shift left logical, zero fill.
  - 10 shift right arithmetic, sign fill.
  - 11 shift right logical, zero fill.
- Count 0 returns In unchanged for every op.
- Only one shifter datapath is instantiated. Its inputs are muxed from the granted requester.
- can_accept = !res_valid || res_ready.
- Grant, combinational:
  - Only one valid: that requester.
  - Both valid: the requester named by the priority pointer prio.
  - None valid: no grant.
- reqX_ready = can_accept && reqX_valid && (grant == X). Both readys are never high in the same cycle.
- Accept means reqX_valid && reqX_ready. On accept, at the clock edge:
  - res_out <= shift(reqX_in, reqX_cnt, reqX_op).
  - res_id <= X.
  - res_valid <= 1.
  - prio <= ~X, so the other requester wins the next tie.
- res_valid && res_ready with no accept that cycle: res_valid <= 0. res_out and res_id hold their last values.
- Drain and accept in the same cycle: the new result replaces the old one and res_valid stays 1. This gives full throughput of one shift per cycle.
- While res_valid && !res_ready:
  - res_out, res_id and res_valid are held stable.
  - Both readys are 0.
  - prio does not change.
- prio changes only on accept. Grant is not locked while a requester waits, so a requester must hold its operands stable while valid && !ready.
- Requester rule: valid may not drop before ready is seen. The arbiter does not check this.

## Timing
- Reset, asynchronous and effective immediately:
  - res_valid = 0, res_out = 0, res_id = 0, prio = 0.
  - req0_ready = req1_ready = 0 while rst is high.
- Reset during a pending result discards that result. No output handshake completes in that cycle.
- Latency: a request accepted at edge k produces res_valid = 1 with its result after edge k.
- Throughput: one accept per cycle when res_ready is held at 1.
- Fairness: when both requesters are continuously valid and the consumer is always ready, grants alternate 0,1,0,1... starting with 0 after reset. Worst-case wait for either requester is one result slot.
- reqX_ready depends combinationally on res_ready, reqX_valid and prio. res_out, res_id and res_valid are register outputs only.

## Test plan
- Single-op check, requester 0 only, res_ready = 1:
  - 0x8001 rotate left 1 -> 0x0003.
  - 0x1234 shift left 4 -> 0x2340.
  - 0x8000 sra 15 -> 0xFFFF.
  - 0x8000 srl 15 -> 0x0001.
  - Each result appears one cycle after accept with res_id = 0.
- Tie after reset: both valid for 4 cycles with distinct operands and res_ready = 1. Required: res_id sequence 0,1,0,1, each res_out matching its own requester's operands, one result per cycle.
- Backpressure: hold res_ready = 0 for 3 cycles with a result pending and both requesters valid. Required: res_out and res_id stable, both readys 0, prio unchanged. When res_ready is raised, the drain and a new accept happen in the same cycle.
- Single requester streaming: req1 valid every cycle, req0 idle. Required: req1 granted every cycle, and prio toggles to 0 after each grant.
- Reset mid-operation: assert rst asynchronously while res_valid = 1 and res_ready = 0. Required: res_valid, res_out and prio are 0 immediately. After release, the first tie is granted to requester 0.
- Count 0 with all four ops on 0xA5A5 -> 0xA5A5 each time.
